// File: rtl/tqv_peri_pkg.sv
// Shared constants for the TinyQV peripheral fabric: read FSM encoding, GPIO register map,
// reserved slot numbers and the default pin routing.
package tqv_peri_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [5:0] GPIO_OUT_OFS = 6'h00;
    localparam logic [5:0] GPIO_IN_OFS  = 6'h04;
    localparam logic [5:0] FUNC_SEL_OFS = 6'h20;
    localparam logic [5:0] STATUS_OFS   = 6'h3C;

    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

    localparam logic [3:0] SLOT_RESERVED = 4'd0;
    localparam logic [3:0] SLOT_GPIO     = 4'd1;
    localparam logic [3:0] SLOT_UART_TX  = 4'd2;
    localparam logic [3:0] SLOT_UART_RX  = 4'd3;

    function automatic logic [4:0] func_sel_reset(input int pin);
        case (pin)
            0:       return {1'b0, SLOT_UART_TX};
            1:       return {1'b0, SLOT_UART_RX};
            default: return {1'b0, SLOT_GPIO};
        endcase
    endfunction

endpackage

// File: rtl/tqv_gpio_regs.sv
// Built-in GPIO slot: gpio_out, per-pin function select, sticky bus-error status and the output pin mux.
// Register reads are combinational; writes take effect on the next clk edge.
module tqv_gpio_regs
    import tqv_peri_pkg::*;
#(
    parameter int N_USER   = 16,
    parameter int N_SIMPLE = 16,
    parameter int N_PINS   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              addr,
    input  logic                    wr_en,
    input  logic [7:0]              wdata,
    input  logic [7:0]              ui_in,
    input  logic                    err_set,
    input  logic [4:0]              err_slot_in,
    input  logic [8*N_USER-1:0]     user_uo,
    input  logic [8*N_SIMPLE-1:0]   simple_uo,
    output logic [31:0]             rdata,
    output logic [N_PINS-1:0]       uo_out
);

    logic [7:0] gpio_out;
    logic [4:0] func_sel [N_PINS];
    logic       err_sticky;
    logic [4:0] err_slot;
    logic [2:0] fs_idx;
    logic       is_fs;

    // The status register overlays the last func_sel word, so status takes 0x3C.
    assign fs_idx = addr[4:2];
    assign is_fs  = addr[5] && (addr[1:0] == 2'b00) && (addr != STATUS_OFS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpio_out   <= '0;
            err_sticky <= 1'b0;
            err_slot   <= '0;
            for (int i = 0; i < N_PINS; i++) func_sel[i] <= func_sel_reset(i);
        end else begin
            if (wr_en && addr == GPIO_OUT_OFS) gpio_out <= wdata;
            for (int i = 0; i < N_PINS; i++)
                if (wr_en && is_fs && fs_idx == 3'(i)) func_sel[i] <= wdata[4:0];
            if (err_set) begin
                err_sticky <= 1'b1;
                err_slot   <= err_slot_in;
            end else if (wr_en && addr == STATUS_OFS && wdata[0]) begin
                err_sticky <= 1'b0;
                err_slot   <= '0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == GPIO_OUT_OFS) begin
            rdata[7:0] = gpio_out;
        end else if (addr == GPIO_IN_OFS) begin
            rdata[7:0] = ui_in;
        end else if (addr == STATUS_OFS) begin
            rdata[0]   = err_sticky;
            rdata[8:4] = err_slot;
        end else begin
            for (int i = 0; i < N_PINS; i++)
                if (is_fs && fs_idx == 3'(i)) rdata[4:0] = func_sel[i];
        end
    end

    always_comb begin
        uo_out = '0;
        for (int i = 0; i < N_PINS; i++) begin
            if (func_sel[i][4]) begin
                for (int j = 0; j < N_SIMPLE; j++)
                    if (func_sel[i][3:0] == 4'(j)) uo_out[i] = simple_uo[8*j+i];
            end else if (func_sel[i][3:0] == SLOT_GPIO) begin
                uo_out[i] = gpio_out[i];
            end else begin
                for (int j = 0; j < N_USER; j++)
                    if (func_sel[i][3:0] == 4'(j)) uo_out[i] = user_uo[8*j+i];
            end
        end
    end

    logic unused_uo;
    assign unused_uo = &{1'b0, user_uo[15:8]};

endmodule

// File: rtl/tqv_peri_fabric.sv
// TinyQV peripheral fabric: slot decode, registered read path with timeout, built-in GPIO slot.
// Reads complete >= 2 cycles after request and hold until consumed; writes complete in one cycle.
module tqv_peri_fabric
    import tqv_peri_pkg::*;
#(
    parameter int N_USER   = 16,
    parameter int N_SIMPLE = 16,
    parameter int N_PINS   = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              ui_in,
    output logic [N_PINS-1:0]       uo_out,
    input  logic [10:0]             addr_in,
    input  logic [31:0]             data_in,
    input  logic [1:0]              data_write_n,
    input  logic [1:0]              data_read_n,
    output logic [31:0]             data_out,
    output logic                    data_ready,
    input  logic                    data_read_complete,
    output logic [N_USER-1:0]       user_sel,
    output logic [N_SIMPLE-1:0]     simple_sel,
    input  logic [32*N_USER-1:0]    user_rdata,
    input  logic [N_USER-1:0]       user_ready,
    input  logic [8*N_SIMPLE-1:0]   simple_rdata,
    input  logic [8*N_USER-1:0]     user_uo,
    input  logic [8*N_SIMPLE-1:0]   simple_uo,
    output logic                    bus_error
);

    logic        is_simple;
    logic [3:0]  user_idx;
    logic [3:0]  simple_idx;
    logic        read_req;
    logic        write_req;
    logic [31:0] sel_rdata;
    logic [31:0] gpio_rdata;
    logic        sel_ready;
    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        rd_ready_r;
    logic        timeout_hit;

    assign is_simple  = addr_in[10];
    assign user_idx   = addr_in[9:6];
    assign simple_idx = addr_in[7:4];
    assign read_req   = (data_read_n != 2'b11);
    assign write_req  = (data_write_n != 2'b11);
    assign data_ready = rd_ready_r | write_req;

    always_comb begin
        user_sel   = '0;
        simple_sel = '0;
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        if (is_simple) begin
            sel_ready = 1'b1;
            for (int i = 0; i < N_SIMPLE; i++)
                if (simple_idx == 4'(i)) begin
                    simple_sel[i] = 1'b1;
                    sel_rdata     = {24'h0, simple_rdata[8*i +: 8]};
                end
        end else if (user_idx == SLOT_GPIO) begin
            user_sel[SLOT_GPIO] = 1'b1;
            sel_ready           = 1'b1;
            sel_rdata           = gpio_rdata;
        end else begin
            // Slot 0 is reserved and never answers; it can only finish by timeout.
            for (int i = 2; i < N_USER; i++)
                if (user_idx == 4'(i)) begin
                    user_sel[i] = 1'b1;
                    sel_ready   = user_ready[i];
                    sel_rdata   = user_rdata[32*i +: 32];
                end
        end
    end

    assign timeout_hit = (state == ST_WAIT) && read_req && !sel_ready && (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            data_out   <= '0;
            rd_ready_r <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_req) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!read_req) begin
                        state <= ST_IDLE;
                    end else if (sel_ready) begin
                        data_out   <= sel_rdata;
                        rd_ready_r <= 1'b1;
                        state      <= ST_HOLD;
                    end else if (timeout_hit) begin
                        data_out   <= ERR_DATA;
                        rd_ready_r <= 1'b1;
                        bus_error  <= 1'b1;
                        state      <= ST_HOLD;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (data_read_complete || !read_req) begin
                        state      <= ST_IDLE;
                        rd_ready_r <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tqv_gpio_regs #(
        .N_USER   (N_USER),
        .N_SIMPLE (N_SIMPLE),
        .N_PINS   (N_PINS)
    ) u_gpio (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr_in[5:0]),
        .wr_en       (write_req && user_sel[SLOT_GPIO]),
        .wdata       (data_in[7:0]),
        .ui_in       (ui_in),
        .err_set     (timeout_hit),
        .err_slot_in ({addr_in[10], addr_in[9:6]}),
        .user_uo     (user_uo),
        .simple_uo   (simple_uo),
        .rdata       (gpio_rdata),
        .uo_out      (uo_out)
    );

    logic unused_bits;
    assign unused_bits = &{1'b0, user_ready[1:0], user_rdata[63:0], data_in[31:8]};

endmodule

// File: tb/tb_tqv_peri_fabric.sv
// Randomized bench for tqv_peri_fabric against a transaction-level model of the slot map, GPIO registers and pin mux.
module tb_tqv_peri_fabric;

    localparam int NU = 16;
    localparam int NS = 16;
    localparam int NP = 8;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      ui_in = '0;
    logic [NP-1:0]   uo_out;
    logic [10:0]     addr_in = '0;
    logic [31:0]     data_in = '0;
    logic [1:0]      data_write_n = 2'b11;
    logic [1:0]      data_read_n = 2'b11;
    logic [31:0]     data_out;
    logic            data_ready;
    logic            data_read_complete = 1'b0;
    logic [NU-1:0]   user_sel;
    logic [NS-1:0]   simple_sel;
    logic [32*NU-1:0] user_rdata = '0;
    logic [NU-1:0]   user_ready = '0;
    logic [8*NS-1:0] simple_rdata = '0;
    logic [8*NU-1:0] user_uo = '0;
    logic [8*NS-1:0] simple_uo = '0;
    logic            bus_error;

    always #5 clk = ~clk;

    tqv_peri_fabric #(.N_USER(NU), .N_SIMPLE(NS), .N_PINS(NP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .addr_in(addr_in), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .data_read_complete(data_read_complete), .user_sel(user_sel),
        .simple_sel(simple_sel), .user_rdata(user_rdata), .user_ready(user_ready),
        .simple_rdata(simple_rdata), .user_uo(user_uo), .simple_uo(simple_uo),
        .bus_error(bus_error)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_gpio;
    logic [4:0] m_fs [NP];
    logic       m_sticky;
    logic [4:0] m_slot;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gpio = '0;
        m_sticky = 1'b0;
        m_slot = '0;
        for (int i = 0; i < NP; i++) m_fs[i] = 5'd1;
        m_fs[0] = 5'd2;
        m_fs[1] = 5'd3;
    endtask

    function automatic logic [NP-1:0] model_uo();
        logic [NP-1:0] v = '0;
        for (int i = 0; i < NP; i++) begin
            int s = int'(m_fs[i][3:0]);
            if (m_fs[i][4])  v[i] = simple_uo[8*s+i];
            else if (s == 1) v[i] = m_gpio[i];
            else             v[i] = user_uo[8*s+i];
        end
        return v;
    endfunction

    function automatic logic [31:0] model_gpio_rd(input logic [5:0] off);
        if (off == 6'h00) return {24'h0, m_gpio};
        if (off == 6'h04) return {24'h0, ui_in};
        if (off == 6'h3C) return {23'h0, m_slot, 3'b000, m_sticky};
        if (off[5] && off[1:0] == 2'b00) return {27'h0, m_fs[off[4:2]]};
        return 32'h0;
    endfunction

    task automatic randomize_ext();
        ui_in = 8'($urandom);
        for (int i = 0; i < NU; i++) begin
            user_rdata[32*i +: 32] = $urandom;
            user_uo[8*i +: 8] = 8'($urandom);
            user_ready[i] = 1'($urandom);
        end
        for (int i = 0; i < NS; i++) begin
            simple_rdata[8*i +: 8] = 8'($urandom);
            simple_uo[8*i +: 8] = 8'($urandom);
        end
    endtask

    task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [1:0] w);
        addr_in = a;
        data_in = d;
        data_write_n = w;
        #1;
        chk("wr_ready", 32'(data_ready), 32'd1);
        @(posedge clk); #1;
        data_write_n = 2'b11;
        if (!a[10] && a[9:6] == 4'd1) begin
            if (a[5:0] == 6'h00) m_gpio = d[7:0];
            else if (a[5:0] == 6'h3C) begin
                if (d[0]) begin m_sticky = 1'b0; m_slot = '0; end
            end else if (a[5] && a[1:0] == 2'b00) m_fs[a[4:2]] = d[4:0];
        end
        chk("wr_uo_out", 32'(uo_out), 32'(model_uo()));
    endtask

    // dly: cycles the addressed external user slot keeps user_ready low after the request.
    task automatic do_read(input logic [10:0] a, input int dly);
        bit simple = a[10];
        int s = int'(a[9:6]);
        int sidx = int'(a[7:4]);
        int lat_exp = 2;
        int lat = 0;
        int berr = 0;
        bit err_exp = 1'b0;
        bit ext = 1'b0;
        logic [31:0] d_exp = '0;
        logic [15:0] us_exp = '0;
        logic [15:0] ss_exp = '0;
        if (simple) begin
            d_exp = {24'h0, simple_rdata[8*sidx +: 8]};
            ss_exp[sidx] = 1'b1;
        end else if (s == 1) begin
            d_exp = model_gpio_rd(a[5:0]);
            us_exp[1] = 1'b1;
        end else if (s == 0) begin
            err_exp = 1'b1;
        end else begin
            ext = 1'b1;
            us_exp[s] = 1'b1;
            d_exp = user_rdata[32*s +: 32];
            user_ready[s] = (dly == 0);
            if (dly + 2 > TO + 1) err_exp = 1'b1;
            else lat_exp = dly + 2;
        end
        if (err_exp) begin
            lat_exp = TO + 1;
            d_exp = 32'hFFFF_FFFF;
        end
        addr_in = a;
        data_read_n = 2'($urandom_range(0, 2));
        #1;
        chk("user_sel", 32'(user_sel), 32'(us_exp));
        chk("simple_sel", 32'(simple_sel), 32'(ss_exp));
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ext && dly > 0 && c == dly + 1) user_ready[s] = 1'b1;
            if (bus_error) berr++;
            if (data_ready) begin
                lat = c;
                break;
            end
        end
        chk("rd_latency", 32'(lat), 32'(lat_exp));
        chk("rd_data", data_out, d_exp);
        @(posedge clk); #1;
        if (bus_error) berr++;
        chk("hold_ready", 32'(data_ready), 32'd1);
        chk("hold_data", data_out, d_exp);
        data_read_complete = 1'b1;
        @(posedge clk); #1;
        data_read_complete = 1'b0;
        data_read_n = 2'b11;
        if (bus_error) berr++;
        chk("rd_release", 32'(data_ready), 32'd0);
        chk("bus_error_cnt", 32'(berr), 32'(err_exp));
        if (ext) user_ready[s] = 1'b0;
        if (err_exp) begin
            m_sticky = 1'b1;
            m_slot = {a[10], a[9:6]};
        end
    endtask

    task automatic do_abort(input int s);
        int seen_rdy = 0;
        int seen_err = 0;
        user_ready[s] = 1'b0;
        addr_in = {1'b0, 4'(s), 6'h00};
        data_read_n = 2'b10;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (c == 3) data_read_n = 2'b11;
            if (data_ready) seen_rdy++;
            if (bus_error) seen_err++;
        end
        chk("abort_ready", 32'(seen_rdy), 32'd0);
        chk("abort_bus_error", 32'(seen_err), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(data_ready), 32'd0);
        chk({tag, "_data"}, data_out, 32'd0);
        chk({tag, "_bus_error"}, 32'(bus_error), 32'd0);
        chk({tag, "_uo_out"}, 32'(uo_out), 32'(model_uo()));
    endtask

    task automatic do_reset_mid_read();
        int seen_rdy = 0;
        int seen_err = 0;
        addr_in = 11'h000;
        data_read_n = 2'b10;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        data_read_n = 2'b11;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        check_reset_state("mid_rst");
        repeat (20) begin
            @(posedge clk); #1;
            if (data_ready) seen_rdy++;
            if (bus_error) seen_err++;
        end
        chk("mid_rst_no_ready", 32'(seen_rdy), 32'd0);
        chk("mid_rst_no_error", 32'(seen_err), 32'd0);
    endtask

    initial begin
        model_reset();
        randomize_ext();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");

        user_rdata[32*4 +: 32] = 32'h1234_5678;
        do_read({1'b0, 4'd4, 6'h00}, 0);
        do_read({1'b0, 4'd0, 6'h00}, 0);
        do_read({1'b0, 4'd1, 6'h3C}, 0);
        do_write({1'b0, 4'd1, 6'h3C}, 32'h1, 2'b10);
        do_read({1'b0, 4'd1, 6'h3C}, 0);
        do_read({1'b1, 2'b00, 4'd3, 4'h0}, 0);
        simple_uo[7:0] = 8'h04;
        do_write({1'b0, 4'd1, 6'h28}, 32'h10, 2'b10);
        chk("fs2_simple0_pin", 32'(uo_out[2]), 32'd1);
        do_write({1'b0, 4'd1, 6'h00}, 32'h05, 2'b00);
        do_write({1'b0, 4'd1, 6'h20}, 32'h01, 2'b10);
        chk("fs0_gpio_pin", 32'(uo_out[0]), 32'd1);
        do_abort(5);
        do_reset_mid_read();
        do_read({1'b0, 4'd1, 6'h3C}, 0);

        for (int it = 0; it < 90; it++) begin
            randomize_ext();
            #1;
            chk("rand_uo_out", 32'(uo_out), 32'(model_uo()));
            case ($urandom_range(0, 6))
                0: do_write({1'b0, 4'd1, 6'h00}, $urandom, 2'($urandom_range(0, 2)));
                1: do_write({1'b0, 4'd1, 6'h20 + 6'(4 * $urandom_range(0, 6))}, $urandom, 2'b10);
                2: do_write({1'b0, 4'd1, 6'h3C}, $urandom, 2'b10);
                3: do_read({1'b0, 4'd1, 6'($urandom)}, 0);
                4: do_read({1'b0, 4'($urandom_range(2, NU - 1)), 6'($urandom)}, $urandom_range(0, 20));
                5: do_read({1'b1, 6'($urandom)}, 0);
                default: do_read({1'b0, 4'd0, 6'($urandom)}, 0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
